// File: rtl/count_stream_buffer.sv
// Stream buffer behind the enable counter: captures valid counts into a FIFO and
// serves them first-word-fall-through on a valid/ready port, dropping and counting overflow.
module count_stream_buffer #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     clear_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     head_ptr;
  logic [LW-1:0]     level_q, level_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              full, pop, push, drop;

  // Next-state: push/pop/drop decisions and the registered FWFT head.
  always_comb begin
    full        = (level_q == LW'(DEPTH));
    pop         = out_valid_q && out_ready;
    push        = in_valid && (!full || pop);
    drop        = in_valid && full && !pop;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    // The next head may be the slot being written this cycle, so bypass the input.
    head_ptr = rd_ptr_d;
    if (level_d != '0) begin
      out_valid_d = 1'b1;
      if (push && (head_ptr == wr_ptr_q)) out_data_d = in_data;
      else                                out_data_d = mem_q[head_ptr];
    end

    // A drop in the same cycle as a clear takes precedence over the clear.
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_ovf)                    drop_cnt_d = DROP_W'(1);
      else if (drop_cnt_q != DROP_MAX)  drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage needs no reset; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_count_stream_buffer.sv
// Directed bench for count_stream_buffer: flow, full/drop, stall, saturation, reset.
module tb_count_stream_buffer;
  localparam int unsigned WIDTH  = 5;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DROP_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  in_data;
  logic              in_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        level;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic              clear_ovf;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] nv, dump, hold_d;
  logic             rdy, vld, hold_v;
  logic [WIDTH-1:0] exp3 [8];

  always #5 clk = ~clk;

  count_stream_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .clear_ovf(clear_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    tick(); tick();
    #2 rst = 1'b1;

    // 1: basic flow, counter running 40 cycles
    out_ready = 1'b1;
    nv = '0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = nv;
      tick();
      check("s1_data", 32'(out_data), 32'(nv));
      check("s1_valid", 32'(out_valid), 1);
      check("s1_level", 32'(level), 1);
      check("s1_ovf", 32'(overflow), 0);
      nv++;
    end
    in_valid = 1'b0;
    tick();
    check("s1_end_valid", 32'(out_valid), 0);
    check("s1_end_hold", 32'(out_data), 7);
    check("s1_end_level", 32'(level), 0);

    // 2: fill to full, then one drop
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(3 + i);
      tick();
      check("s2_level", 32'(level), 32'(i + 1));
      check("s2_head", 32'(out_data), 3);
    end
    check("s2_valid", 32'(out_valid), 1);
    in_data = WIDTH'(11);
    tick();
    check("s2_ovf", 32'(overflow), 1);
    check("s2_drop", 32'(drop_cnt), 1);
    check("s2_level_full", 32'(level), 8);
    check("s2_head_kept", 32'(out_data), 3);

    // 3: push+pop while full, then drain
    out_ready = 1'b1; in_data = WIDTH'(20);
    tick();
    check("s3_level", 32'(level), 8);
    check("s3_drop", 32'(drop_cnt), 1);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) exp3[i] = WIDTH'(4 + i);
    exp3[7] = WIDTH'(20);
    for (int i = 0; i < 8; i++) begin
      check("s3_drain_data", 32'(out_data), 32'(exp3[i]));
      check("s3_drain_valid", 32'(out_valid), 1);
      tick();
    end
    check("s3_empty_valid", 32'(out_valid), 0);
    check("s3_empty_level", 32'(level), 0);

    // 4: stall stability with random ready, scoreboard queue
    out_ready = 1'b0; nv = WIDTH'(12);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = nv; q.push_back(nv); nv++;
      tick();
    end
    check("s4_level3", 32'(level), 3);
    for (int i = 0; i < 50; i++) begin
      rdy = 1'($urandom_range(0, 1));
      vld = (q.size() < 7) && 1'($urandom_range(0, 1));
      out_ready = rdy; in_valid = vld; in_data = nv;
      hold_v = (q.size() > 0) && !rdy;
      hold_d = (q.size() > 0) ? q[0] : '0;
      if (q.size() > 0 && rdy) dump = q.pop_front();
      if (vld) begin q.push_back(nv); nv++; end
      tick();
      if (hold_v) begin
        check("s4_stall_data", 32'(out_data), 32'(hold_d));
        check("s4_stall_valid", 32'(out_valid), 1);
      end
      check("s4_level", 32'(level), 32'(q.size()));
      if (q.size() > 0) begin
        check("s4_valid", 32'(out_valid), 1);
        check("s4_head", 32'(out_data), 32'(q[0]));
      end else begin
        check("s4_idle", 32'(out_valid), 0);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    for (int g = 0; g < 20 && q.size() > 0; g++) begin
      check("s4_drain_head", 32'(out_data), 32'(q[0]));
      dump = q.pop_front();
      tick();
    end
    check("s4_drained_valid", 32'(out_valid), 0);
    check("s4_drained_level", 32'(level), 0);

    // 5: drop saturation and clear
    out_ready = 1'b0; clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("s5_pre_ovf", 32'(overflow), 0);
    check("s5_pre_drop", 32'(drop_cnt), 0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      tick();
    end
    in_data = WIDTH'(31);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 0)   check("s5_drop1", 32'(drop_cnt), 1);
      if (i == 253) check("s5_drop254", 32'(drop_cnt), 254);
      if (i == 254) check("s5_drop255", 32'(drop_cnt), 255);
    end
    check("s5_sat", 32'(drop_cnt), 255);
    check("s5_ovf", 32'(overflow), 1);
    check("s5_level", 32'(level), 8);
    in_valid = 1'b0; clear_ovf = 1'b1;
    tick();
    check("s5_clr_ovf", 32'(overflow), 0);
    check("s5_clr_drop", 32'(drop_cnt), 0);
    check("s5_clr_level", 32'(level), 8);
    check("s5_clr_head", 32'(out_data), 0);
    in_valid = 1'b1;
    tick();
    check("s5_race_ovf", 32'(overflow), 1);
    check("s5_race_drop", 32'(drop_cnt), 1);
    in_valid = 1'b0; clear_ovf = 1'b0;

    // 6: mid-operation asynchronous reset
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("s6_level5", 32'(level), 5);
    check("s6_head", 32'(out_data), 3);
    out_ready = 1'b0;
    #2 rst = 1'b0;
    in_valid = 1'b1; in_data = WIDTH'(9);
    #1;
    check("s6_rst_valid", 32'(out_valid), 0);
    check("s6_rst_data", 32'(out_data), 0);
    check("s6_rst_level", 32'(level), 0);
    check("s6_rst_ovf", 32'(overflow), 0);
    check("s6_rst_drop", 32'(drop_cnt), 0);
    #9 rst = 1'b1;
    in_data = WIDTH'(7);
    tick();
    check("s6_first_data", 32'(out_data), 7);
    check("s6_first_valid", 32'(out_valid), 1);
    check("s6_first_level", 32'(level), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("s6_pop_valid", 32'(out_valid), 0);
    check("s6_pop_hold", 32'(out_data), 7);
    check("s6_pop_level", 32'(level), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
